// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the parity helper.
// Used by both the receive deserialiser and the transmit side.
package uart_pkg;

   localparam logic [1:0] ENC_IDLE   = 2'd0;
   localparam logic [1:0] ENC_DATA   = 2'd1;
   localparam logic [1:0] ENC_PARITY = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = ENC_IDLE,
      ST_DATA   = ENC_DATA,
      ST_PARITY = ENC_PARITY
   } uart_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int MAX_DATA_W = 16;

   // Returns 1 when word plus parity bit violate the selected parity mode.
   function automatic logic parity_calc(input logic                  odd,
                                        input logic [MAX_DATA_W-1:0] word,
                                        input logic                  pbit);
      return (^word) ^ pbit ^ odd;
   endfunction

endpackage

// File: rtl/uart_shift_reg.sv
// Frame shift register: synchronous clear, shift-in on enable, configurable bit order.
module uart_shift_reg #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         if (LSB_FIRST != 0) begin
            q_d = {din, q_q[WIDTH-1:1]};
         end else begin
            q_d = {q_q[WIDTH-2:0], din};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: frame FSM, bit counter, optional parity check and a
// registered output word with valid/ready handshake and sticky overrun flag.
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LSB_FIRST  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              data_in,
   input  logic              shift,
   input  logic              data_ready,
   input  logic              clr_overrun,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic              ODD_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   uart_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              parity_err_q, parity_err_d;
   logic              overrun_q, overrun_d;
   logic              busy_q, busy_d;

   logic [DATA_W-1:0] sr;
   logic [DATA_W-1:0] sr_next;
   logic [DATA_W-1:0] final_word;
   logic              sr_clr;
   logic              sr_en;
   logic              complete;
   logic              perr;
   logic              load;

   uart_shift_reg #(
      .WIDTH     (DATA_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (sr_clr),
      .en    (sr_en),
      .din   (data_in),
      .q     (sr)
   );

   // Value the shift register takes on this strobe; needed when the last data bit completes the word.
   assign sr_next = (LSB_FIRST != 0) ? {data_in, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], data_in};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_clr     = 1'b0;
      sr_en      = 1'b0;
      complete   = 1'b0;
      perr       = 1'b0;
      final_word = sr_next;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               sr_clr  = 1'b1;
            end
         end
         ST_DATA: begin
            if (start) begin
               cnt_d  = '0;
               sr_clr = 1'b1;
            end else if (shift) begin
               sr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state_d = ST_PARITY;
                  end else begin
                     state_d  = ST_IDLE;
                     complete = 1'b1;
                  end
               end
            end
         end
         ST_PARITY: begin
            if (start) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               sr_clr  = 1'b1;
            end else if (shift) begin
               state_d    = ST_IDLE;
               complete   = 1'b1;
               final_word = sr;
               perr       = parity_calc(ODD_MODE, MAX_DATA_W'(sr), data_in);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      load = complete && (!data_valid_q || data_ready);

      data_out_d   = data_out_q;
      parity_err_d = parity_err_q;
      data_valid_d = data_valid_q;
      if (data_valid_q && data_ready) begin
         data_valid_d = 1'b0;
      end
      if (load) begin
         data_out_d   = final_word;
         parity_err_d = perr;
         data_valid_d = 1'b1;
      end

      // A dropped word must win over a simultaneous clear so it is never lost silently.
      overrun_d = overrun_q;
      if (clr_overrun) begin
         overrun_d = 1'b0;
      end
      if (complete && !load) begin
         overrun_d = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: four configurations share one stimulus bus; a vector table
// covers word assembly and parity, hand sequences cover handshake, abort and reset.
module tb_uart_rx_deser;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic data_in = 1'b0;
   logic shift = 1'b0;
   logic data_ready = 1'b0;
   logic clr_overrun = 1'b0;

   logic [7:0] dout [4];
   logic       dv   [4];
   logic       pe   [4];
   logic       ov   [4];
   logic       bz   [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // 0: LSB first, no parity   1: MSB first, no parity
   // 2: LSB first, even parity 3: LSB first, odd parity
   uart_rx_deser #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_lsb (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .shift(shift),
      .data_ready(data_ready), .clr_overrun(clr_overrun), .data_out(dout[0]),
      .data_valid(dv[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bz[0]));

   uart_rx_deser #(.DATA_W(8), .LSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u_msb (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .shift(shift),
      .data_ready(data_ready), .clr_overrun(clr_overrun), .data_out(dout[1]),
      .data_valid(dv[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bz[1]));

   uart_rx_deser #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u_pev (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .shift(shift),
      .data_ready(data_ready), .clr_overrun(clr_overrun), .data_out(dout[2]),
      .data_valid(dv[2]), .parity_err(pe[2]), .overrun(ov[2]), .busy(bz[2]));

   uart_rx_deser #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u_pod (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .shift(shift),
      .data_ready(data_ready), .clr_overrun(clr_overrun), .data_out(dout[3]),
      .data_valid(dv[3]), .parity_err(pe[3]), .overrun(ov[3]), .busy(bz[3]));

   typedef struct {
      logic [8:0] bits;      // bits[i] is the i-th received bit
      int         nbits;
      int         dut;
      logic [7:0] exp_data;
      logic       exp_perr;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called right after an active edge (+1); returns right after the last shift edge (+1).
   task automatic send(input logic [8:0] bits, input int n, input bit rdy_last);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         data_in = bits[i];
         shift   = 1'b1;
         if (rdy_last && i == n - 1) data_ready = 1'b1;
         @(posedge clk); #1;
         shift = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{bits: 9'h0A5, nbits: 8, dut: 0, exp_data: 8'hA5, exp_perr: 1'b0};
      vecs[1] = '{bits: 9'h083, nbits: 8, dut: 1, exp_data: 8'hC1, exp_perr: 1'b0};
      vecs[2] = '{bits: 9'h083, nbits: 8, dut: 0, exp_data: 8'h83, exp_perr: 1'b0};
      vecs[3] = '{bits: 9'h107, nbits: 9, dut: 2, exp_data: 8'h07, exp_perr: 1'b0};
      vecs[4] = '{bits: 9'h007, nbits: 9, dut: 2, exp_data: 8'h07, exp_perr: 1'b1};
      vecs[5] = '{bits: 9'h007, nbits: 9, dut: 3, exp_data: 8'h07, exp_perr: 1'b0};
      vecs[6] = '{bits: 9'h107, nbits: 9, dut: 3, exp_data: 8'h07, exp_perr: 1'b1};
      vecs[7] = '{bits: 9'h048, nbits: 8, dut: 1, exp_data: 8'h12, exp_perr: 1'b0};
      vecs[8] = '{bits: 9'h0FF, nbits: 8, dut: 0, exp_data: 8'hFF, exp_perr: 1'b0};
      vecs[9] = '{bits: 9'h000, nbits: 8, dut: 0, exp_data: 8'h00, exp_perr: 1'b0};

      // Reset state of every configuration.
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_dout%0d", d), dout[d], 8'h00);
         chk($sformatf("rst_valid%0d", d), dv[d], 1'b0);
         chk($sformatf("rst_perr%0d", d), pe[d], 1'b0);
         chk($sformatf("rst_ovr%0d", d), ov[d], 1'b0);
         chk($sformatf("rst_busy%0d", d), bz[d], 1'b0);
      end
      reset = 1'b0;
      @(posedge clk); #1;

      // Table of frames; words are consumed as soon as they appear.
      data_ready = 1'b1;
      for (int v = 0; v < 10; v++) begin
         send(vecs[v].bits, vecs[v].nbits, 1'b0);
         chk($sformatf("vec%0d_data", v), dout[vecs[v].dut], vecs[v].exp_data);
         chk($sformatf("vec%0d_valid", v), dv[vecs[v].dut], 1'b1);
         chk($sformatf("vec%0d_perr", v), pe[vecs[v].dut], vecs[v].exp_perr);
         chk($sformatf("vec%0d_busy", v), bz[vecs[v].dut], 1'b0);
      end
      @(posedge clk); #1;
      chk("consumed_valid", dv[0], 1'b0);

      // Overrun: two completions with the consumer stalled.
      reset = 1'b1;
      #2;
      reset = 1'b0;
      data_ready = 1'b0;
      @(posedge clk); #1;
      send(9'h011, 8, 1'b0);
      chk("ovr_first_data", dout[0], 8'h11);
      chk("ovr_first_valid", dv[0], 1'b1);
      chk("ovr_first_flag", ov[0], 1'b0);
      send(9'h022, 8, 1'b0);
      chk("ovr_keep_data", dout[0], 8'h11);
      chk("ovr_flag", ov[0], 1'b1);
      chk("ovr_keep_valid", dv[0], 1'b1);
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      clr_overrun = 1'b0;
      chk("ovr_cleared", ov[0], 1'b0);

      // Completion in the same cycle the pending word is consumed.
      send(9'h033, 8, 1'b1);
      chk("same_cyc_valid", dv[0], 1'b1);
      chk("same_cyc_data", dout[0], 8'h33);
      chk("same_cyc_ovr", ov[0], 1'b0);
      @(posedge clk); #1;
      chk("same_cyc_drain", dv[0], 1'b0);
      chk("same_cyc_hold", dout[0], 8'h33);

      // Abort after four bits, then a complete frame.
      send(9'h0FF, 4, 1'b0);
      chk("abort_busy", bz[0], 1'b1);
      chk("abort_novalid", dv[0], 1'b0);
      send(9'h05A, 8, 1'b0);
      chk("abort_data", dout[0], 8'h5A);
      chk("abort_valid", dv[0], 1'b1);
      @(posedge clk); #1;

      // Asynchronous reset after three bits; later strobes in IDLE are ignored.
      send(9'h1FF, 3, 1'b0);
      chk("mid_busy", bz[0], 1'b1);
      reset = 1'b1;
      #2;
      chk("mid_rst_data", dout[0], 8'h00);
      chk("mid_rst_valid", dv[0], 1'b0);
      chk("mid_rst_busy", bz[0], 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         data_in = 1'b1;
         shift   = 1'b1;
         @(posedge clk); #1;
         shift = 1'b0;
      end
      chk("idle_shift_valid", dv[0], 1'b0);
      chk("idle_shift_data", dout[0], 8'h00);
      chk("idle_shift_busy", bz[0], 1'b0);

      // start and shift together: the bit must not be sampled.
      start   = 1'b1;
      shift   = 1'b1;
      data_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      shift = 1'b0;
      chk("start_busy", bz[0], 1'b1);
      for (int i = 0; i < 8; i++) begin
         data_in = vecs[0].bits[i];
         shift   = 1'b1;
         @(posedge clk); #1;
         shift = 1'b0;
      end
      chk("start_shift_data", dout[0], 8'hA5);
      chk("start_shift_valid", dv[0], 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
